// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - serial gain/accumulate/saturate mixer of NUM_CH signed PCM channels
// Optional AUDIO_MIXER_DC_BLOCK_EN adds a first-order DC-blocking high-pass stage on dout.
module audio_mixer #(
    parameter int AUDIO_DW   = 16,
    parameter int NUM_CH     = 4,
    parameter int GAIN_W     = 4,
    parameter int GAIN_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_stb,
    input  logic [NUM_CH*AUDIO_DW-1:0] din,
    input  logic [NUM_CH*GAIN_W-1:0]   gain,
    output logic [AUDIO_DW-1:0]        dout,
    output logic                       dout_valid,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       overrun_clr
);
    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int PROD_W = AUDIO_DW + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + IDX_W;

`ifdef AUDIO_MIXER_DC_BLOCK_EN
    typedef enum logic [1:0] {IDLE, ACC, SAT, DCB} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;
`endif

    state_t state, state_nxt;

    logic [AUDIO_DW-1:0]      snap_din  [NUM_CH];
    logic [GAIN_W-1:0]        snap_gain [NUM_CH];
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic signed [PROD_W-1:0] din_ext, gain_ext, prod, term;
    logic [ACC_W-AUDIO_DW:0]  acc_top;
    logic [AUDIO_DW-1:0]      sat_val;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (sample_stb) state_nxt = ACC;
            ACC:  if (idx == IDX_W'(NUM_CH - 1)) state_nxt = SAT;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            SAT:  state_nxt = DCB;
            DCB:  state_nxt = IDLE;
`else
            SAT:  state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Full-precision signed x zero-extended gain, then floor shift; acc is wide enough never to wrap.
    always_comb begin
        din_ext  = PROD_W'(signed'(snap_din[idx]));
        gain_ext = signed'({{(AUDIO_DW + 1){1'b0}}, snap_gain[idx]});
        prod     = din_ext * gain_ext;
        term     = prod >>> GAIN_SHIFT;
        acc_nxt  = acc + ACC_W'(term);
        acc_top  = acc[ACC_W-1:AUDIO_DW-1];
        if (&acc_top || ~|acc_top) sat_val = acc[AUDIO_DW-1:0];
        else if (acc[ACC_W-1])     sat_val = {1'b1, {(AUDIO_DW - 1){1'b0}}};
        else                       sat_val = {1'b0, {(AUDIO_DW - 1){1'b1}}};
    end

`ifdef AUDIO_MIXER_DC_BLOCK_EN
    localparam int Y_W = AUDIO_DW + 2;
    logic [AUDIO_DW-1:0]   s_cur, s_prev, y_prev, y_sat;
    logic signed [Y_W-1:0] y_full;
    logic [2:0]            y_top;

    // y = s - s_prev + y_prev - y_prev/1024, re-clamped to the output width
    always_comb begin
        y_full = Y_W'(signed'(s_cur)) - Y_W'(signed'(s_prev)) + Y_W'(signed'(y_prev))
               - Y_W'(signed'(y_prev) >>> 10);
        y_top  = y_full[Y_W-1:AUDIO_DW-1];
        if (&y_top || ~|y_top) y_sat = y_full[AUDIO_DW-1:0];
        else if (y_full[Y_W-1]) y_sat = {1'b1, {(AUDIO_DW - 1){1'b0}}};
        else                    y_sat = {1'b0, {(AUDIO_DW - 1){1'b1}}};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            idx        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_din[k]  <= '0;
                snap_gain[k] <= '0;
            end
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            s_cur  <= '0;
            s_prev <= '0;
            y_prev <= '0;
`endif
        end else begin
            dout_valid <= 1'b0;
            if (sample_stb && state != IDLE) overrun <= 1'b1;
            else if (overrun_clr)            overrun <= 1'b0;
            case (state)
                IDLE: if (sample_stb) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        snap_din[k]  <= din[k*AUDIO_DW +: AUDIO_DW];
                        snap_gain[k] <= gain[k*GAIN_W +: GAIN_W];
                    end
                    acc <= '0;
                    idx <= '0;
                end
                ACC: begin
                    acc <= acc_nxt;
                    idx <= idx + 1'b1;
                end
`ifdef AUDIO_MIXER_DC_BLOCK_EN
                SAT: s_cur <= sat_val;
                DCB: begin
                    dout       <= y_sat;
                    dout_valid <= 1'b1;
                    s_prev     <= s_cur;
                    y_prev     <= y_sat;
                end
`else
                SAT: begin
                    dout       <= sat_val;
                    dout_valid <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_mixer.sv
// tb/tb_audio_mixer.sv - scoreboard bench for audio_mixer against an arithmetic reference model
module tb_audio_mixer;
    localparam int DW   = 16;
    localparam int NCH  = 4;
    localparam int GW   = 4;
    localparam int GS   = 3;
    localparam int QMAX = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_stb = 1'b0;
    logic              overrun_clr = 1'b0;
    logic [NCH*DW-1:0] din = '0;
    logic [NCH*GW-1:0] gain = '0;
    logic [DW-1:0]     dout;
    logic              dout_valid, busy, overrun;

    audio_mixer #(.AUDIO_DW(DW), .NUM_CH(NCH), .GAIN_W(GW), .GAIN_SHIFT(GS)) dut (
        .clk(clk), .rst(rst), .sample_stb(sample_stb), .din(din), .gain(gain),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: step() pushes, monitor pops
    logic [DW-1:0] exp_val   [QMAX];
    int            exp_vedge [QMAX];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            last_s = -1000;
    logic          exp_busy = 1'b0;
    logic          exp_ovr  = 1'b0;
    logic [DW-1:0] exp_dout = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mix(input logic [NCH*DW-1:0] d, input logic [NCH*GW-1:0] g);
        int sum;
        int s;
        int w;
        int hi;
        int lo;
        sum = 0;
        hi  = (1 <<< (DW - 1)) - 1;
        lo  = -(1 <<< (DW - 1));
        for (int k = 0; k < NCH; k++) begin
            s = int'($signed(d[k*DW +: DW]));
            w = int'(g[k*GW +: GW]);
            sum += (s * w) >>> GS;
        end
        if (sum > hi) sum = hi;
        else if (sum < lo) sum = lo;
        return sum[DW-1:0];
    endfunction

    function automatic logic [NCH*DW-1:0] p4(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [NCH*GW-1:0] g4(input logic [GW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Drive one edge's inputs and predict the DUT state right after that edge.
    task automatic step(input logic stb, input logic [NCH*DW-1:0] d, input logic [NCH*GW-1:0] g,
                        input logic clr, input logic r);
        int  e;
        bit  idle;
        @(negedge clk);
        #1;
        sample_stb  = stb;
        din         = d;
        gain        = g;
        overrun_clr = clr;
        rst         = r;
        e    = cyc + 1;
        idle = (e >= last_s + NCH + 2);
        if (r) begin
            last_s   = -1000;
            exp_ovr  = 1'b0;
        end else begin
            if (stb && idle) begin
                last_s            = e;
                exp_val[wr_ptr]   = mix(d, g);
                exp_vedge[wr_ptr] = e + NCH + 1;
                wr_ptr++;
            end
            if (stb && !idle) exp_ovr = 1'b1;
            else if (clr)     exp_ovr = 1'b0;
        end
        exp_busy = (e - last_s >= 0) && (e - last_s <= NCH);
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(1'b0, {$urandom, $urandom}, 16'($urandom), 1'b0, 1'b0);
    endtask

    // Valid is expected exactly NUM_CH+1 edges after the accepting edge, i.e. a
    // synchronous consumer captures it NUM_CH+2 edges after the strobe edge.
    always @(negedge clk) begin
        logic want_valid;
        if (rst) begin
            rd_ptr   = wr_ptr;
            exp_dout = '0;
        end
        want_valid = (rd_ptr < wr_ptr) && (cyc == exp_vedge[rd_ptr]);
        check("dout_valid_timing", 32'(dout_valid), 32'(want_valid));
        if (want_valid) begin
            exp_dout = exp_val[rd_ptr];
            rd_ptr++;
        end
        check("dout", 32'(dout), 32'(exp_dout));
        check("busy", 32'(busy), 32'(exp_busy));
        check("overrun", 32'(overrun), 32'(exp_ovr));
    end

    initial begin
        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1);
        idle_n(2);

        step(1'b1, p4(16'h2000, 16'h0, 16'h0, 16'h0), g4(8, 0, 0, 0), 1'b0, 1'b0);
        idle_n(7);

        step(1'b1, p4(16'h2000, 16'hE000, 16'h0, 16'h0), g4(8, 8, 8, 8), 1'b0, 1'b0);
        step(1'b0, p4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), g4(15, 15, 15, 15), 1'b0, 1'b0);
        idle_n(6);

        step(1'b1, p4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), g4(15, 15, 15, 15), 1'b0, 1'b0);
        idle_n(6);
        step(1'b1, p4(16'h8000, 16'h8000, 16'h8000, 16'h8000), g4(15, 15, 15, 15), 1'b0, 1'b0);
        idle_n(6);
        step(1'b1, p4(16'hFFFF, 16'h0, 16'h0, 16'h0), g4(1, 0, 0, 0), 1'b0, 1'b0);
        idle_n(6);

        step(1'b1, p4(16'h1234, 16'h0100, 16'hF000, 16'h0042), g4(8, 4, 3, 15), 1'b0, 1'b0);
        idle_n(2);
        step(1'b1, p4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), g4(15, 15, 15, 15), 1'b0, 1'b0);
        idle_n(4);
        step(1'b1, p4(16'h0400, 16'h0, 16'h0, 16'h0), g4(8, 0, 0, 0), 1'b0, 1'b0);
        step(1'b1, p4(16'h7FFF, 16'h0, 16'h0, 16'h0), g4(8, 0, 0, 0), 1'b1, 1'b0);
        step(1'b0, p4(16'h0, 16'h0, 16'h0, 16'h0), g4(0, 0, 0, 0), 1'b1, 1'b0);
        idle_n(5);

        step(1'b1, p4(16'h0100, 16'h0200, 16'h0300, 16'h0400), g4(8, 8, 8, 8), 1'b0, 1'b0);
        idle_n(NCH + 1);
        step(1'b1, p4(16'hFF00, 16'h0010, 16'h0, 16'h0), g4(15, 2, 0, 0), 1'b0, 1'b0);
        idle_n(7);

        step(1'b1, p4(16'h2000, 16'h2000, 16'h0, 16'h0), g4(8, 8, 0, 0), 1'b0, 1'b0);
        idle_n(1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        idle_n(2);
        step(1'b1, p4(16'h0123, 16'hF321, 16'h0, 16'h5555), g4(9, 7, 0, 2), 1'b0, 1'b0);
        idle_n(7);

        repeat (400)
            step($urandom_range(0, 3) == 0, {$urandom, $urandom}, 16'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        idle_n(10);
        check("scoreboard_drained", 32'(wr_ptr - rd_ptr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
- Downstream of the 1-bit-to-PCM source stages (mic, beeper/EAR and similar converters).
- Snapshots NUM_CH signed PCM channels on a sample strobe and applies a 4-bit gain to each channel.
- Accumulates the channels serially, one per clock, then saturates the sum to AUDIO_DW.
- Presents one registered mixed sample with a valid pulse to the audio output path (I2S/PWM serializer).

Parameters:
- AUDIO_DW, 16, width of each signed two's-complement input sample and of the output sample.
- NUM_CH, 4, number of input channels (2..16).
- GAIN_W, 4, width of each per-channel unsigned gain field.
- GAIN_SHIFT, 3, arithmetic right shift after the gain multiply. Gain 8 with shift 3 is unity.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_stb  in  1  single-cycle request to produce one mixed sample.
- din  in  NUM_CH*AUDIO_DW  packed signed samples; channel k occupies bits [k*AUDIO_DW +: AUDIO_DW].
- gain  in  NUM_CH*GAIN_W  packed unsigned gains, laid out the same way as din.
- dout  out  AUDIO_DW  signed mixed sample, held between updates.
- dout_valid  out  1  one-cycle pulse when dout updates.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  sticky flag: a strobe arrived while busy.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (rst high at a clk edge):
  - dout=0, dout_valid=0, busy=0, overrun=0, state=IDLE.
  - Accumulator, channel index and snapshot all cleared.
  - Reset mid-mix abandons the mix; no dout_valid is produced.
- States:
  - IDLE to ACC when sample_stb=1.
  - ACC to SAT after the last channel (idx=NUM_CH-1).
  - SAT to IDLE.
- Edge T0 (sample_stb=1 in IDLE):
  - din and gain captured into the snapshot registers.
  - acc=0, idx=0, busy=1, state=ACC.
  - Inputs may change freely after T0.
- ACC, one channel per edge (edges T1..T_NUM_CH):
  - term = (snap_din[idx] * gain[idx]) >>> GAIN_SHIFT.
  - The multiply is signed x zero-extended unsigned, full precision (AUDIO_DW+GAIN_W+1 bits).
  - The shift is arithmetic (floor toward minus infinity).
  - acc += term. acc width is AUDIO_DW+GAIN_W+clog2(NUM_CH)+1, so it never wraps.
- SAT (edge T_NUM_CH+1):
  - dout = clamp(acc, -2^(AUDIO_DW-1), 2^(AUDIO_DW-1)-1).
  - dout_valid=1 for exactly this one cycle; busy=0; state=IDLE.
- Latency: dout_valid is high in the cycle following edge T_NUM_CH+1, i.e. NUM_CH+2 edges after the strobe edge.
- sample_stb while busy (including the SAT cycle):
  - The strobe is ignored and the current mix is unaffected.
  - overrun is set to 1.
- sample_stb in the cycle immediately after SAT, once back in IDLE, is accepted normally. Back-to-back throughput is one sample per NUM_CH+2 cycles.
- overrun:
  - overrun_clr=1 clears it.
  - If overrun_clr and a dropped strobe occur on the same edge, set wins (overrun=1).
- Gain 0 mutes a channel. Gain 15 gives 1.875x, so the saturation path is reachable even with a single channel.

Optional Feature:
- Macro: AUDIO_MIXER_DC_BLOCK_EN.
- Defined:
  - Adds state DCB between SAT and IDLE.
  - The saturated value s feeds a first-order high-pass: y = s - s_prev + y_prev - (y_prev >>> 10).
  - y is computed at AUDIO_DW+2 bits, re-saturated to AUDIO_DW, and drives dout.
  - s_prev and y_prev update only on accepted samples and reset to 0.
  - dout_valid moves one cycle later (NUM_CH+3 edges after the strobe edge).
  - busy covers DCB; strobes during DCB count as overrun.
- Undefined: no DCB state, no filter registers; behaviour exactly as above.

Test Plan (NUM_CH=4, AUDIO_DW=16, GAIN_SHIFT=3, macro undefined unless stated):
- Single channel: ch0=0x2000 gain 8, others 0 -> dout=0x2000, dout_valid exactly 6 edges after the strobe edge, busy high 5 cycles.
- Mixed signs: ch0=0x2000, ch1=0xE000 (-0x2000), all gains 8 -> dout=0x0000. Change din/gain to all 0x7FFF on the cycle after the strobe -> result unchanged.
- Saturation:
  - All channels 0x7FFF, gain 15 -> dout=0x7FFF.
  - All channels 0x8000, gain 15 -> dout=0x8000.
  - ch0=0xFFFF gain 1 -> term=-1 (floor), dout=0xFFFF.
- Overrun:
  - Strobe at T0 and at T3 -> one dout_valid, overrun=1.
  - overrun_clr together with a dropped strobe -> overrun stays 1; overrun_clr alone next cycle -> 0.
  - Strobe on the first IDLE cycle after SAT -> accepted.
- Reset mid-mix: rst at T2 -> no dout_valid, dout=0, busy=0; a fresh strobe afterwards mixes correctly.
- AUDIO_MIXER_DC_BLOCK_EN defined: constant ch0=0x2000 gain 8 over repeated strobes -> first dout=0x2000, later outputs decay monotonically toward 0, dout_valid at 7 edges after the strobe edge.
